// File: rtl/cy10lp_ram_pkg.sv
// Shared types and constants for the on-chip RAM stream master.
package cy10lp_ram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [7:0] BE_LANE0 = 8'h0F;
   localparam logic [7:0] BE_LANE1 = 8'hF0;

   // Byte enables selecting one 32-bit lane of a 64-bit RAM word.
   function automatic logic [7:0] lane_be(input logic lane);
      return lane ? BE_LANE1 : BE_LANE0;
   endfunction

endpackage

// File: rtl/cy10lp_sfifo.sv
// Small synchronous FIFO with show-ahead output and an occupancy count.
module cy10lp_sfifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   // A push into a full buffer is dropped; the master never offers one.
   assign do_push    = push_i && (count_q != CNT_W'(DEPTH));
   assign do_pop     = pop_i && (count_q != '0);
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // Storage array, written at the tail.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/cy10lp_ram_stream_master.sv
// Avalon-MM master bridging 32-bit valid/ready streams to a 64-bit
// single-port RAM with one-cycle read latency, one lane per access.
module cy10lp_ram_stream_master
   import cy10lp_ram_pkg::*;
#(
   parameter int ADDR_W        = 13,
   parameter int LEN_W         = 15,
   parameter int RD_FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_dir_i,
   input  logic [ADDR_W:0]   cmd_addr_i,
   input  logic [LEN_W-1:0]  cmd_len_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic [31:0]       wr_data_i,
   output logic              rd_valid_o,
   input  logic              rd_ready_i,
   output logic [31:0]       rd_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] avm_address_o,
   output logic [7:0]        avm_byteenable_o,
   output logic              avm_chipselect_o,
   output logic              avm_write_o,
   output logic [63:0]       avm_writedata_o,
   output logic              avm_clken_o,
   input  logic [63:0]       avm_readdata_i
);

   localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_LIM = RD_FIFO_DEPTH[CNT_W:0];

   state_e              state_q;
   logic [ADDR_W:0]     lane_addr_q;
   logic [LEN_W-1:0]    rem_q;
   logic                cmd_ready_q;
   logic                busy_q;
   logic                done_q;
   logic                wr_ready_q;
   logic [ADDR_W-1:0]   avm_address_q;
   logic [7:0]          avm_byteenable_q;
   logic                avm_chipselect_q;
   logic                avm_write_q;
   logic [63:0]         avm_writedata_q;
   logic                rd_str_lane_q;
   logic                rd_ret_q;
   logic                rd_ret_lane_q;

   logic                wr_fire;
   logic                rd_strobe;
   logic                rd_issue;
   logic [CNT_W:0]      rd_commit;
   logic                fifo_push;
   logic [31:0]         fifo_push_data;
   logic                fifo_pop;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;

   assign wr_fire   = wr_valid_i && wr_ready_q;
   assign rd_strobe = avm_chipselect_q && !avm_write_q;

   // Reads are in flight from the strobe cycle until their data lands in
   // the FIFO, so both stages reserve a buffer slot before a new issue.
   assign rd_commit = {1'b0, fifo_count}
                    + {{CNT_W{1'b0}}, rd_strobe}
                    + {{CNT_W{1'b0}}, rd_ret_q};
   assign rd_issue  = (state_q == ST_READ) && (rem_q != '0) && (rd_commit < DEPTH_LIM);

   assign fifo_push      = rd_ret_q;
   assign fifo_push_data = rd_ret_lane_q ? avm_readdata_i[63:32] : avm_readdata_i[31:0];
   assign fifo_pop       = rd_ready_i && !fifo_empty;

   cy10lp_sfifo #(
      .WIDTH (32),
      .DEPTH (RD_FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_rd_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .push_i      (fifo_push),
      .push_data_i (fifo_push_data),
      .pop_i       (fifo_pop),
      .pop_data_o  (rd_data_o),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Read-return pipeline: RAM data is valid the cycle after the strobe.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ret_q      <= 1'b0;
         rd_ret_lane_q <= 1'b0;
      end else begin
         rd_ret_q      <= rd_strobe;
         rd_ret_lane_q <= rd_str_lane_q;
      end
   end

   // Command FSM with counters and registered stream/Avalon outputs.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q          <= ST_IDLE;
         lane_addr_q      <= '0;
         rem_q            <= '0;
         cmd_ready_q      <= 1'b1;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         wr_ready_q       <= 1'b0;
         avm_address_q    <= '0;
         avm_byteenable_q <= '0;
         avm_chipselect_q <= 1'b0;
         avm_write_q      <= 1'b0;
         avm_writedata_q  <= '0;
         rd_str_lane_q    <= 1'b0;
      end else begin
         avm_chipselect_q <= 1'b0;
         avm_write_q      <= 1'b0;
         done_q           <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid_i && cmd_ready_q) begin
                  lane_addr_q <= cmd_addr_i;
                  rem_q       <= cmd_len_i;
                  busy_q      <= 1'b1;
                  cmd_ready_q <= 1'b0;
                  if (cmd_len_i == '0) begin
                     state_q <= ST_DONE;
                  end else if (cmd_dir_i) begin
                     state_q <= ST_READ;
                  end else begin
                     state_q    <= ST_WRITE;
                     wr_ready_q <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (wr_fire) begin
                  avm_chipselect_q <= 1'b1;
                  avm_write_q      <= 1'b1;
                  avm_address_q    <= lane_addr_q[ADDR_W:1];
                  avm_byteenable_q <= lane_be(lane_addr_q[0]);
                  avm_writedata_q  <= {wr_data_i, wr_data_i};
                  lane_addr_q      <= lane_addr_q + (ADDR_W+1)'(1);
                  rem_q            <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     wr_ready_q <= 1'b0;
                     state_q    <= ST_DONE;
                  end
               end
            end
            ST_READ: begin
               if (rd_issue) begin
                  avm_chipselect_q <= 1'b1;
                  avm_address_q    <= lane_addr_q[ADDR_W:1];
                  avm_byteenable_q <= lane_be(lane_addr_q[0]);
                  rd_str_lane_q    <= lane_addr_q[0];
                  lane_addr_q      <= lane_addr_q + (ADDR_W+1)'(1);
                  rem_q            <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (!rd_strobe && !rd_ret_q && fifo_empty) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o      = cmd_ready_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign wr_ready_o       = wr_ready_q;
   assign rd_valid_o       = !fifo_empty;
   assign avm_address_o    = avm_address_q;
   assign avm_byteenable_o = avm_byteenable_q;
   assign avm_chipselect_o = avm_chipselect_q;
   assign avm_write_o      = avm_write_q;
   assign avm_writedata_o  = avm_writedata_q;
   assign avm_clken_o      = 1'b1;

endmodule

// File: tb/tb_cy10lp_ram_stream_master.sv
// Bench for cy10lp_ram_stream_master with a 1-cycle-latency RAM model and a
// lane-level golden memory image.
module tb_cy10lp_ram_stream_master;

   localparam int ADDR_W = 13;
   localparam int LEN_W  = 15;
   localparam int DEPTH  = 4;
   localparam int LANES  = 16384;
   localparam int WORDS  = 8192;

   typedef struct packed {
      logic        wr;
      logic [12:0] addr;
      logic [7:0]  be;
      logic [63:0] wd;
      logic [31:0] cyc;
   } strobe_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid, cmd_ready, cmd_dir;
   logic [ADDR_W:0]   cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              wr_valid, wr_ready;
   logic [31:0]       wr_data;
   logic              rd_valid, rd_ready;
   logic [31:0]       rd_data;
   logic              busy, done;
   logic [ADDR_W-1:0] avm_address;
   logic [7:0]        avm_byteenable;
   logic              avm_chipselect, avm_write, avm_clken;
   logic [63:0]       avm_writedata, avm_readdata;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   logic [31:0] golden [LANES];
   logic [63:0] ram [WORDS];
   logic        ram_init;
   strobe_t     stq[$];
   int          pop_cyc[$];

   always #5 clk = ~clk;

   cy10lp_ram_stream_master #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_dir_i(cmd_dir),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
      .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
      .busy_o(busy), .done_o(done),
      .avm_address_o(avm_address), .avm_byteenable_o(avm_byteenable),
      .avm_chipselect_o(avm_chipselect), .avm_write_o(avm_write),
      .avm_writedata_o(avm_writedata), .avm_clken_o(avm_clken),
      .avm_readdata_i(avm_readdata)
   );

   always @(posedge clk) cycle <= cycle + 1;

   // RAM slave: byte-enabled writes, read data valid only the cycle after a read strobe.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int w = 0; w < WORDS; w++) ram[w] <= {golden[2*w+1], golden[2*w]};
      end else if (avm_chipselect && avm_write) begin
         for (int b = 0; b < 8; b++)
            if (avm_byteenable[b]) ram[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
      end
      if (avm_chipselect && !avm_write) avm_readdata <= ram[avm_address];
      else avm_readdata <= {$urandom, $urandom};
   end

   // Strobe log.
   always @(negedge clk) begin
      if (avm_chipselect)
         stq.push_back('{wr: avm_write, addr: avm_address, be: avm_byteenable,
                         wd: avm_writedata, cyc: cycle});
   end

   task automatic send_cmd(input logic dir, input logic [13:0] addr, input logic [14:0] len);
      int w;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = addr; cmd_len = len;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++; $display("FAIL cmd_accept: cmd_ready=%b required=1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_write(input logic [13:0] addr, input int len, input int gap_pct,
                            input bit fixed, input string tag, output int done_cyc);
      logic [31:0] dat[$];
      logic [13:0] la;
      int idx, cyc;
      bit got;
      for (int i = 0; i < len; i++) dat.push_back(fixed ? 32'h11111111 * (i + 1) : $urandom);
      stq.delete();
      send_cmd(1'b0, addr, 15'(len));
      idx = 0; cyc = 0; got = 0; done_cyc = -1;
      while (!got && cyc < 3000) begin
         if (idx < len && $urandom_range(99) >= gap_pct) begin
            wr_valid = 1'b1; wr_data = dat[idx];
         end else begin
            wr_valid = 1'b0; wr_data = $urandom;
         end
         @(negedge clk);
         if (wr_valid && wr_ready) idx++;
         cyc++;
         if (done) begin got = 1; done_cyc = cyc; end
         else begin @(posedge clk); #1; end
      end
      wr_valid = 1'b0;
      total++;
      if (!got || idx != len) begin
         bad++; $display("FAIL %s write_done: done=%0d beats=%0d required done=1 beats=%0d", tag, got, idx, len);
      end
      total++;
      if (stq.size() != len) begin
         bad++; $display("FAIL %s write_strobes: count=%0d required=%0d", tag, stq.size(), len);
      end
      for (int i = 0; i < len && i < stq.size(); i++) begin
         la = addr + 14'(i);
         golden[la] = dat[i];
         total++;
         if ({stq[i].wr, stq[i].addr, stq[i].be, stq[i].wd} !==
             {1'b1, la[13:1], la[0] ? 8'hF0 : 8'h0F, dat[i], dat[i]}) begin
            bad++;
            $display("FAIL %s write_strobe%0d: wr=%b addr=%h be=%h wd=%h required addr=%h be=%h wd=%h",
                     tag, i, stq[i].wr, stq[i].addr, stq[i].be, stq[i].wd,
                     la[13:1], la[0] ? 8'hF0 : 8'h0F, {dat[i], dat[i]});
         end
      end
      if (len > 0 && stq.size() > 0) begin
         total++;
         if (got && int'(stq[stq.size()-1].cyc) >= cycle) begin
            bad++; $display("FAIL %s done_after_strobe: done_cycle=%0d last_strobe=%0d", tag, cycle, stq[stq.size()-1].cyc);
         end
      end
      @(posedge clk); #1;
      for (int i = -1; i <= len; i++) begin
         la = addr + 14'(i);
         total++;
         if (ram[la[13:1]][la[0]*32 +: 32] !== golden[la]) begin
            bad++; $display("FAIL %s ram_lane %h: got=%h required=%h", tag, la, ram[la[13:1]][la[0]*32 +: 32], golden[la]);
         end
      end
   endtask

   task automatic run_read(input logic [13:0] addr, input int len, input int stall_pct,
                           input int hold, input string tag, output int done_cyc);
      logic [13:0] la;
      logic [31:0] held_d;
      bit held_v, got;
      int beats, cyc, nrd;
      stq.delete(); pop_cyc.delete();
      send_cmd(1'b1, addr, 15'(len));
      beats = 0; cyc = 0; got = 0; held_v = 0; held_d = '0; done_cyc = -1;
      while (!got && cyc < 3000) begin
         rd_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) >= stall_pct);
         @(negedge clk);
         if (hold > 0 && cyc == hold - 1) begin
            #1;
            nrd = 0;
            foreach (stq[k]) if (!stq[k].wr) nrd++;
            total++;
            if (nrd != DEPTH) begin
               bad++; $display("FAIL %s stalled_reads: issued=%0d required=%0d", tag, nrd, DEPTH);
            end
         end
         if (held_v) begin
            total++;
            if ({rd_valid, rd_data} !== {1'b1, held_d}) begin
               bad++; $display("FAIL %s rd_hold: valid=%b data=%h required valid=1 data=%h", tag, rd_valid, rd_data, held_d);
            end
         end
         if (rd_valid && rd_ready) begin
            la = addr + 14'(beats);
            total++;
            if (rd_data !== golden[la]) begin
               bad++; $display("FAIL %s rd_beat%0d: got=%h required=%h", tag, beats, rd_data, golden[la]);
            end
            beats++;
            pop_cyc.push_back(cycle);
         end
         held_v = rd_valid && !rd_ready;
         held_d = rd_data;
         cyc++;
         if (done) begin got = 1; done_cyc = cyc; end
         else begin @(posedge clk); #1; end
      end
      rd_ready = 1'b0;
      total++;
      if (!got || beats != len) begin
         bad++; $display("FAIL %s read_done: done=%0d beats=%0d required done=1 beats=%0d", tag, got, beats, len);
      end
      total++;
      if (stq.size() != len) begin
         bad++; $display("FAIL %s read_strobes: count=%0d required=%0d", tag, stq.size(), len);
      end
      for (int i = 0; i < len && i < stq.size(); i++) begin
         la = addr + 14'(i);
         total++;
         if ({stq[i].wr, stq[i].addr} !== {1'b0, la[13:1]}) begin
            bad++; $display("FAIL %s read_strobe%0d: wr=%b addr=%h required wr=0 addr=%h", tag, i, stq[i].wr, stq[i].addr, la[13:1]);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd_valid = 0; cmd_dir = 0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 0; wr_data = '0; rd_ready = 0; ram_init = 1'b1;
      for (int l = 0; l < LANES; l++) golden[l] = $urandom;
      repeat (3) @(negedge clk);
      ram_init = 1'b0;
      total++;
      if ({cmd_ready, busy, done, wr_ready, rd_valid, avm_chipselect, avm_write, avm_clken,
           avm_byteenable, avm_address, avm_writedata} !== {8'b1000_0001, 8'h00, 13'h0, 64'h0}) begin
         bad++;
         $display("FAIL reset_values: rdy=%b busy=%b done=%b wrr=%b rdv=%b cs=%b we=%b clken=%b be=%h addr=%h wd=%h required rdy=1 clken=1 others 0",
                  cmd_ready, busy, done, wr_ready, rd_valid, avm_chipselect, avm_write, avm_clken,
                  avm_byteenable, avm_address, avm_writedata);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_basic();
      int dc;
      run_write(14'd0, 4, 0, 1'b1, "wr_basic", dc);
      total++;
      if ({ram[0], ram[1]} !== {64'h22222222_11111111, 64'h44444444_33333333}) begin
         bad++; $display("FAIL wr_basic words: w0=%h w1=%h required w0=2222222211111111 w1=4444444433333333", ram[0], ram[1]);
      end
   endtask

   task automatic test_read_basic();
      int dc;
      run_read(14'd1, 3, 0, 0, "rd_basic", dc);
      total++;
      if (pop_cyc.size() != 3 || pop_cyc[2] - pop_cyc[0] != 2) begin
         bad++; $display("FAIL rd_basic consecutive: beats=%0d span=%0d required beats=3 span=2",
                         pop_cyc.size(), pop_cyc.size() == 3 ? pop_cyc[2] - pop_cyc[0] : -1);
      end
   endtask

   task automatic test_backpressure();
      int dc;
      run_read(14'd0, 8, 0, 10, "rd_stall", dc);
   endtask

   task automatic test_wrap();
      int dc;
      run_write(14'd16383, 2, 0, 1'b0, "wr_wrap", dc);
      total++;
      if ({ram[8191][63:32], ram[0][31:0]} !== {golden[16383], golden[0]}) begin
         bad++; $display("FAIL wr_wrap lanes: hi8191=%h lo0=%h required %h %h", ram[8191][63:32], ram[0][31:0], golden[16383], golden[0]);
      end
   endtask

   task automatic test_zero_len();
      int dc;
      run_write(14'($urandom), 0, 0, 1'b0, "wr_zero", dc);
      total++;
      if (dc < 1 || dc > 2) begin
         bad++; $display("FAIL wr_zero latency: cycles=%0d required 1..2", dc);
      end
      run_read(14'($urandom), 0, 0, 0, "rd_zero", dc);
      total++;
      if (dc < 1 || dc > 2) begin
         bad++; $display("FAIL rd_zero latency: cycles=%0d required 1..2", dc);
      end
   endtask

   task automatic test_random();
      int dc, len, pct;
      logic [13:0] a;
      for (int n = 0; n < 10; n++) begin
         a   = 14'($urandom);
         len = $urandom_range(24, 1);
         pct = $urandom_range(60, 0);
         if ($urandom_range(1) == 0) run_write(a, len, pct, 1'b0, "rand_wr", dc);
         else                        run_read(a, len, pct, 0, "rand_rd", dc);
      end
   endtask

   task automatic test_back_to_back();
      int dc;
      run_write(14'd100, 6, 0, 1'b0, "b2b_wr", dc);
      run_read(14'd100, 6, 0, 0, "b2b_rd", dc);
   endtask

   task automatic test_reset_mid_read();
      int dc;
      stq.delete();
      send_cmd(1'b1, 14'd5, 15'd8);
      rd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      total++;
      if ({cmd_ready, busy, done, wr_ready, rd_valid, avm_chipselect, avm_write, avm_clken,
           avm_byteenable, avm_address, avm_writedata} !== {8'b1000_0001, 8'h00, 13'h0, 64'h0}) begin
         bad++;
         $display("FAIL midreset_values: rdy=%b busy=%b done=%b rdv=%b cs=%b be=%h addr=%h required rdy=1 clken=1 others 0",
                  cmd_ready, busy, done, rd_valid, avm_chipselect, avm_byteenable, avm_address);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({rd_valid, busy} !== 2'b00) begin
         bad++; $display("FAIL midreset_fifo: rd_valid=%b busy=%b required 0 0", rd_valid, busy);
      end
      run_read(14'd0, 4, 0, 0, "post_reset_rd", dc);
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_back_to_back();
      test_random();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
